// File: rtl/dbus_arbiter.sv
// Two-requester data bus arbiter with a per-transaction completion timeout.
// Optional round-robin tie-break is enabled by defining DBUS_ARB_RR_EN.
// Packed layouts: req = {valid, addr[31:0], size[2:0], strobe[7:0], data[63:0]},
//                 resp = {addr_ok, data_ok, rdata[63:0]}.
module dbus_arbiter #(
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [107:0] dreq0,
   output logic [65:0]  dresp0,
   input  logic [107:0] dreq1,
   output logic [65:0]  dresp1,
   output logic [107:0] dreq,
   input  logic [65:0]  dresp,
   output logic         owner,
   output logic         timeout_err
);

   localparam int REQ_W       = 108;
   localparam int RESP_W      = 66;
   localparam int VALID_BIT   = 107;
   localparam int ADDR_OK_BIT = 65;
   localparam int DATA_OK_BIT = 64;
   localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY0 = 2'd1,
      BUSY1 = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [REQ_W-1:0]   dreq_q, dreq_d;
   logic               owner_q, owner_d;
   logic [15:0]        wait_q, wait_d;
   logic               terr_q, terr_d;
   logic               req0_s, req1_s, pick_s, done_s;
   logic [15:0]        wait_inc_s;

   assign req0_s     = dreq0[VALID_BIT];
   assign req1_s     = dreq1[VALID_BIT];
   assign done_s     = dresp[ADDR_OK_BIT] & dresp[DATA_OK_BIT];
   assign wait_inc_s = wait_q + 16'd1;

`ifdef DBUS_ARB_RR_EN
   logic rr_q;
   logic grant_s;

   assign grant_s = (state_q == IDLE) && (req0_s || req1_s);
   assign pick_s  = (req0_s && req1_s) ? rr_q : req1_s;

   // Pointer names the requester favoured on the next tie (the last loser)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_q <= 1'b0;
      end else if (grant_s) begin
         rr_q <= ~pick_s;
      end
   end
`else
   assign pick_s = ~req0_s;
`endif

   // Next-state logic: grant from IDLE, finish or abort from BUSY
   always_comb begin
      state_d = state_q;
      dreq_d  = dreq_q;
      owner_d = owner_q;
      wait_d  = wait_q;
      terr_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0_s || req1_s) begin
               state_d = pick_s ? BUSY1 : BUSY0;
               dreq_d  = pick_s ? dreq1 : dreq0;
               owner_d = pick_s;
               wait_d  = 16'd0;
            end else begin
               dreq_d  = {REQ_W{1'b0}};
            end
         end
         BUSY0, BUSY1: begin
            // Completion wins over a timeout landing in the same cycle
            if (done_s) begin
               state_d = IDLE;
               dreq_d  = {REQ_W{1'b0}};
            end else if (wait_inc_s == TIMEOUT_C) begin
               state_d = IDLE;
               dreq_d  = {REQ_W{1'b0}};
               wait_d  = wait_inc_s;
               terr_d  = 1'b1;
            end else begin
               wait_d  = wait_inc_s;
            end
         end
         default: begin
            state_d = IDLE;
            dreq_d  = {REQ_W{1'b0}};
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         dreq_q  <= {REQ_W{1'b0}};
         owner_q <= 1'b0;
         wait_q  <= 16'd0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dreq_q  <= dreq_d;
         owner_q <= owner_d;
         wait_q  <= wait_d;
         terr_q  <= terr_d;
      end
   end

   assign dreq        = dreq_q;
   assign owner       = owner_q;
   assign timeout_err = terr_q;
   assign dresp0      = (state_q == BUSY0) ? dresp : {RESP_W{1'b0}};
   assign dresp1      = (state_q == BUSY1) ? dresp : {RESP_W{1'b0}};

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter (default fixed-priority build, TIMEOUT=4).
module tb_dbus_arbiter;

   logic         clk;
   logic         rst;
   logic [107:0] dreq0, dreq1, dreq;
   logic [65:0]  dresp0, dresp1, dresp;
   logic         owner, timeout_err;
   int           total;
   int           bad;
   logic [107:0] r0, r1, r1b;
   logic [65:0]  ok_rsp;

   dbus_arbiter #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .dreq0(dreq0), .dresp0(dresp0),
      .dreq1(dreq1), .dresp1(dresp1),
      .dreq(dreq), .dresp(dresp),
      .owner(owner), .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [107:0] mkreq(input logic v, input logic [31:0] a,
                                          input logic [2:0] sz, input logic [7:0] st,
                                          input logic [63:0] d);
      return {v, a, sz, st, d};
   endfunction

   function automatic logic [65:0] mkrsp(input logic aok, input logic dok, input logic [63:0] rd);
      return {aok, dok, rd};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_req(input string tag, input logic [107:0] obs, input logic [107:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_rsp(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      rst    = 1'b0;
      dreq0  = '0;
      dreq1  = '0;
      dresp  = '0;
      ok_rsp = mkrsp(1'b1, 1'b1, 64'h0000_0000_1234_5678);
      r0     = mkreq(1'b1, 32'h8000_0010, 3'd2, 8'h00, 64'h0);

      // Reset state, with a request already pending
      tick();
      dreq0 = r0;
      tick();
      chk_req("rst_dreq", dreq, 108'd0);
      chk_bit("rst_owner", owner, 1'b0);
      chk_bit("rst_terr", timeout_err, 1'b0);
      chk_rsp("rst_dresp0", dresp0, 66'd0);
      rst = 1'b1;

      // Single read from requester 0, completes on third BUSY cycle
      tick();
      chk_req("rd_grant", dreq, r0);
      chk_bit("rd_owner", owner, 1'b0);
      tick();
      tick();
      dresp = ok_rsp;
      #1;
      chk_rsp("rd_dresp0", dresp0, ok_rsp);
      chk_rsp("rd_dresp1", dresp1, 66'd0);
      dreq0 = '0;
      tick();
      dresp = '0;
      chk_bit("rd_done_valid", dreq[107], 1'b0);
      chk_rsp("rd_idle_dresp0", dresp0, 66'd0);

      // Contention: 0 first, then 1 after an IDLE cycle; 1 is a write that moves addr mid-BUSY
      r1  = mkreq(1'b1, 32'h0000_2000, 3'd3, 8'hFF, 64'h0000_0000_DEAD_BEEF);
      r1b = mkreq(1'b1, 32'h0000_3000, 3'd3, 8'hFF, 64'h0000_0000_1111_2222);
      dreq0 = mkreq(1'b1, 32'h0000_1000, 3'd2, 8'h00, 64'h0);
      dreq1 = r1;
      tick();
      chk_req("ct_grant0", dreq, mkreq(1'b1, 32'h0000_1000, 3'd2, 8'h00, 64'h0));
      chk_bit("ct_owner0", owner, 1'b0);
      dresp = ok_rsp;
      #1;
      chk_bit("ct_dok0", dresp0[64], 1'b1);
      chk_rsp("ct_nonowner1", dresp1, 66'd0);
      dreq0 = '0;
      tick();
      dresp = '0;
      chk_req("ct_idle_gap", dreq, 108'd0);
      tick();
      chk_req("ct_grant1", dreq, r1);
      chk_bit("ct_owner1", owner, 1'b1);
      dreq1 = r1b;
      tick();
      chk_req("wr_hold", dreq, r1);
      dresp = ok_rsp;
      #1;
      chk_rsp("wr_dresp1", dresp1, ok_rsp);
      chk_rsp("wr_nonowner0", dresp0, 66'd0);
      dreq1 = '0;
      tick();
      dresp = '0;
      chk_bit("wr_done_valid", dreq[107], 1'b0);
      chk_bit("wr_owner_kept", owner, 1'b1);

      // Timeout: no response, abort 4 BUSY cycles after grant
      dreq0 = r0;
      tick();
      chk_bit("to_grant", dreq[107], 1'b1);
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk_bit("to_busy_valid", dreq[107], 1'b1);
         chk_bit("to_busy_terr", timeout_err, 1'b0);
      end
      tick();
      chk_bit("to_abort_valid", dreq[107], 1'b0);
      chk_bit("to_abort_terr", timeout_err, 1'b1);
      chk_bit("to_abort_dok", dresp0[64], 1'b0);

      // Re-grant, then complete exactly when the count reaches TIMEOUT
      tick();
      chk_bit("to_pulse_end", timeout_err, 1'b0);
      chk_req("co_grant", dreq, r0);
      tick();
      tick();
      tick();
      dresp = ok_rsp;
      #1;
      chk_rsp("co_dresp0", dresp0, ok_rsp);
      dreq0 = '0;
      tick();
      dresp = '0;
      chk_bit("co_done_valid", dreq[107], 1'b0);
      chk_bit("co_terr", timeout_err, 1'b0);

      // Reset during BUSY1 drops the bus at once and suppresses responses
      dreq1 = r1;
      tick();
      chk_bit("rs_owner1", owner, 1'b1);
      dresp = ok_rsp;
      #2;
      rst = 1'b0;
      #1;
      chk_req("rs_dreq", dreq, 108'd0);
      chk_rsp("rs_dresp1", dresp1, 66'd0);
      chk_bit("rs_owner", owner, 1'b0);
      dresp = '0;
      dreq1 = '0;
      dreq0 = r0;
      tick();
      chk_req("rs_held", dreq, 108'd0);
      rst = 1'b1;
      tick();
      chk_req("rs_regrant", dreq, r0);
      chk_bit("rs_regrant_owner", owner, 1'b0);
      dresp = ok_rsp;
      dreq0 = '0;
      tick();
      dresp = '0;
      chk_bit("rs_done_valid", dreq[107], 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
